uart_rx_16x: RTL and testbench

UART receiver: the consumer of the 16x oversampling baud clock produced by the divider. Runs entirely on `sysclk` and treats `baudclk` as a data input whose rising edges are sampling ticks; at the 9600-baud divider setting there are 16 ticks per bit. Deserialises 8N1 frames from the `rx` pin into a held byte with a valid/ack handshake toward the CPU peripheral bus.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_sync_edge.sv | 17 +
 rtl/uart_rx_16x.sv | 81 ++++++++
 tb/tb_uart_rx_16x.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_sync_edge.sv
// uart_sync_edge: 2-flop synchroniser with a registered copy for rising-edge detection.
module uart_sync_edge #(
   parameter logic INIT = 1'b0
) (
   input  logic sysclk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);
   logic s1, s2, s3;
   always_ff @(posedge sysclk or negedge reset)
      if (!reset) {s1, s2, s3} <= {3{INIT}};
      else        {s1, s2, s3} <= {din, s1, s2};
   assign level = s2;
   assign rise  = s2 & ~s3;
endmodule

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 8N1 receiver sampling on baudclk ticks, with valid/ack handshake and overrun/frame error flags.
import uart_pkg::*;
module uart_rx_16x #(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 baudclk,
   input  logic                 rx,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 overrun,
   output logic                 frame_err
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   rx_state_t state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [DATA_BITS-1:0] sh;
   logic tick, rxs, load;
   uart_sync_edge #(.INIT(1'b0)) u_baud (
      .sysclk(sysclk), .reset(reset), .din(baudclk), .level(), .rise(tick)
   );
   // rx resets to idle-high so release from reset never looks like a start edge
   uart_sync_edge #(.INIT(1'b1)) u_rx (
      .sysclk(sysclk), .reset(reset), .din(rx), .level(rxs), .rise()
   );
   assign load = tick && state == STOP && cnt == LAST && rxs;
   always_ff @(posedge sysclk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         rx_valid  <= load | (rx_valid & ~rx_ack);
         overrun   <= (overrun | (load & rx_valid)) & ~rx_ack;
         if (load) rx_data <= sh;
         if (tick)
            case (state)
               IDLE:
                  if (!rxs) begin
                     state <= START;
                     cnt   <= '0;
                  end
               START:
                  if (cnt == HALF) begin
                     state <= rxs ? IDLE : DATA;
                     cnt   <= '0;
                     idx   <= '0;
                  end else cnt <= cnt + 1'b1;
               DATA:
                  if (cnt == LAST) begin
                     sh[idx] <= rxs;
                     cnt     <= '0;
                     idx     <= idx + 1'b1;
                     if (idx == IW'(DATA_BITS - 1)) state <= STOP;
                  end else cnt <= cnt + 1'b1;
               STOP:
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     state     <= rxs ? IDLE : BREAK;
                     frame_err <= ~rxs;
                  end else cnt <= cnt + 1'b1;
               BREAK:
                  if (rxs) state <= IDLE;
               default:
                  state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: directed frames against hand-computed expectations for uart_rx_16x.
module tb_uart_rx_16x;
   logic sysclk = 1'b0;
   logic reset = 1'b0;
   logic baudclk = 1'b0;
   logic rx = 1'b1;
   logic rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic rx_valid, overrun, frame_err;
   int tests = 0;
   int failed = 0;
   int fe_cycles = 0;
   int valid_rises = 0;
   int fe0, vr0;
   logic prev_valid = 1'b0;

   uart_rx_16x dut (
      .sysclk(sysclk), .reset(reset), .baudclk(baudclk), .rx(rx), .rx_ack(rx_ack),
      .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun), .frame_err(frame_err)
   );

   always #5 sysclk = ~sysclk;
   // one baud tick every 8 sysclk cycles, edges placed on sysclk falling edges
   always begin
      repeat (4) @(negedge sysclk);
      baudclk = ~baudclk;
   end

   always @(negedge sysclk) begin
      if (frame_err) fe_cycles++;
      if (rx_valid && !prev_valid) valid_rises++;
      prev_valid = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // call right after a baudclk falling edge; returns with the stop level still driven
   task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_ticks);
      rx = 1'b0;
      repeat (16) @(negedge baudclk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (16) @(negedge baudclk);
      end
      rx = stop;
      repeat (stop_ticks) @(negedge baudclk);
   endtask

   task automatic pulse_ack;
      @(negedge sysclk) rx_ack = 1'b1;
      @(negedge sysclk) rx_ack = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge sysclk);
      chk("reset_data", rx_data, 8'h00);
      chk("reset_valid", rx_valid, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      chk("reset_ferr", frame_err, 1'b0);
      @(negedge sysclk) reset = 1'b1;
      repeat (4) @(negedge baudclk);

      fe0 = fe_cycles;
      send_frame(8'hA5, 1'b1, 16);
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_valid", rx_valid, 1'b1);
      chk("a5_overrun", overrun, 1'b0);
      chk("a5_no_ferr", fe_cycles - fe0, 0);
      @(negedge sysclk) rx_ack = 1'b1;
      @(negedge sysclk) rx_ack = 1'b0;
      chk("ack_clears_valid", rx_valid, 1'b0);

      repeat (4) @(negedge baudclk);
      rx = 1'b0;
      repeat (4) @(negedge baudclk);
      rx = 1'b1;
      repeat (30) @(negedge baudclk);
      chk("glitch_valid", rx_valid, 1'b0);
      chk("glitch_data", rx_data, 8'hA5);

      fe0 = fe_cycles;
      send_frame(8'h3C, 1'b0, 16);
      repeat (40) @(negedge baudclk);
      chk("ferr_one_pulse", fe_cycles - fe0, 1);
      chk("ferr_valid", rx_valid, 1'b0);
      chk("ferr_data", rx_data, 8'hA5);
      rx = 1'b1;
      repeat (4) @(negedge baudclk);
      send_frame(8'h81, 1'b1, 16);
      chk("after_break_data", rx_data, 8'h81);
      chk("after_break_valid", rx_valid, 1'b1);
      pulse_ack();

      repeat (4) @(negedge baudclk);
      send_frame(8'h11, 1'b1, 9);
      send_frame(8'h22, 1'b1, 16);
      chk("b2b_data", rx_data, 8'h22);
      chk("b2b_valid", rx_valid, 1'b1);
      chk("b2b_overrun", overrun, 1'b1);
      pulse_ack();
      chk("b2b_ack_valid", rx_valid, 1'b0);
      chk("b2b_ack_overrun", overrun, 1'b0);

      repeat (4) @(negedge baudclk);
      vr0 = valid_rises;
      rx = 1'b0;
      repeat (16) @(negedge baudclk);
      rx = 1'b1;
      repeat (16 * 4 + 8) @(negedge baudclk);
      @(negedge sysclk) reset = 1'b0;
      repeat (2) @(negedge sysclk);
      chk("midrst_data", rx_data, 8'h00);
      chk("midrst_valid", rx_valid, 1'b0);
      chk("midrst_overrun", overrun, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      @(negedge sysclk) reset = 1'b1;
      repeat (100) @(negedge baudclk);
      send_frame(8'h5A, 1'b1, 16);
      chk("post_rst_data", rx_data, 8'h5A);
      chk("post_rst_valid", rx_valid, 1'b1);
      chk("post_rst_one_byte", valid_rises - vr0, 1);

      // ack lands on the same sysclk edge that registers the stop-sample tick
      repeat (4) @(negedge baudclk);
      send_frame(8'h77, 1'b1, 0);
      repeat (9) @(posedge baudclk);
      repeat (2) @(negedge sysclk);
      rx_ack = 1'b1;
      @(negedge sysclk) rx_ack = 1'b0;
      chk("same_cycle_data", rx_data, 8'h77);
      chk("same_cycle_valid", rx_valid, 1'b1);
      chk("same_cycle_overrun", overrun, 1'b0);
      repeat (10) @(negedge baudclk);
      chk("same_cycle_hold", rx_valid, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
